rs_dispatch_ctrl: RTL
=====================

// Module: rs_dispatch_ctrl
// PURPOSE
//  Issue-side scheduler for the reservation stations (alu0, alu1, ls, branch).
//  Accepts one decoded instruction per cycle via valid/ready and picks a free RS
//  (alu0/alu1 shared round-robin). Drives the one-cycle allocate enable that the
//  RS samples at posedge. Masks the RS busy-flag latency with local reservations.
//  Holds issue while a branch is unresolved and handles mispredict flush.
// PARAMETERS
//  BUSY_LAT     2  cycles a dispatched RS stays reserved if its busy input has not risen
//  BR_STALL     1  1: block all issue while a branch is in flight; 0: block only branches
//  FLUSH_CYC    1  cycles issue stays blocked after a taken-branch redirect
// PORTS
//  clk            in   1  clock, all state on posedge
//  rst            in   1  synchronous, active-high reset
//  rdy            in   1  global ready; when 0, state frozen and all en_* held 0
//  inst_valid     in   1  decoded instruction present
//  inst_class     in   2  0=ALU 1=LS 2=BRANCH 3=NOP (retired with no RS)
//  inst_ready     out  1  instruction accepted this cycle (comb from state+inputs)
//  busy_alu0      in   1  RS busy flags, as driven by each RS
//  busy_alu1      in   1
//  busy_ls        in   1
//  busy_branch    in   1
//  br_done        in   1  branch unit resolved its branch (1-cycle pulse)
//  br_taken       in   1  qualifies br_done: redirect/mispredict
//  en_alu0        out  1  allocate pulse to RS alu0
//  en_alu1        out  1
//  en_ls          out  1
//  en_branch      out  1
//  flush          out  1  high for FLUSH_CYC cycles after br_done&br_taken
//  stall_cnt      out 16  cycles with inst_valid&!inst_ready, saturating
// BEHAVIOUR
//  Reset: en_*=0, flush=0, stall_cnt=0, reservations clear, rr pointer=alu0, FSM=ISSUE.
//  free(x) = !busy_x & !resv_x. resv_x set on dispatch to x; cleared when busy_x seen 1
//   or after BUSY_LAT cycles (per-RS counter), whichever first.
//  FSM ISSUE: accept if class free: ALU -> rr choice if free else other ALU if free;
//   LS -> ls; BRANCH -> branch; NOP -> always accepted, no en_*.
//   inst_ready = inst_valid & target free & !flush; en_x = inst_ready & target==x (same cycle).
//   Branch dispatch -> BR_WAIT. rr pointer toggles only on ALU dispatch, to the unused ALU.
//  BR_WAIT: BR_STALL=1 -> inst_ready=0; BR_STALL=0 -> ALU/LS/NOP issue, BRANCH blocked.
//   br_done&!br_taken -> ISSUE next cycle; br_done&br_taken -> FLUSH.
//  FLUSH: flush=1 for FLUSH_CYC cycles, inst_ready=0, all reservations cleared; -> ISSUE.
//  br_done in ISSUE state ignored. Simultaneous br_done and new branch offer in BR_WAIT:
//   resolve first; new branch waits at least one cycle.
//  Never more than one en_* high per cycle; never en_x while busy_x=1 or resv_x=1.
//  rdy=0: no accept, counters/FSM/reservations frozen, en_*=0, stall_cnt not incremented.
//  rst mid-branch: returns to ISSUE, outstanding branch forgotten, flush not asserted.
//  stall_cnt saturates at 16'hFFFF, does not wrap.
// TESTING
//  ALU,ALU,ALU back-to-back, all idle -> en_alu0, en_alu1, then stall until a resv clears.
//  busy_alu0=1 persistent, ALU stream -> every dispatch to en_alu1, none to alu0.
//  BRANCH then LS with BR_STALL=1 -> en_branch, LS held (stall_cnt++) until br_done,
//   LS issues cycle after br_done&!br_taken.
//  br_done&br_taken -> flush=1 exactly FLUSH_CYC cycles, inst_ready=0, resv cleared.
//  Dispatch LS, busy_ls never rises -> ls reserved BUSY_LAT=2 cycles, next LS 3rd cycle.
//  rdy=0 for 5 cycles with inst_valid -> no en_*, stall_cnt unchanged; rst -> all zero.

Source files
------------

// File: rtl/rs_dispatch_ctrl.sv
// Issue-side dispatcher for the alu0/alu1/ls/branch reservation stations: picks a free RS,
// covers RS busy-flag latency with local reservations, and sequences branch wait / flush.
module rs_dispatch_ctrl #(
   parameter int BUSY_LAT  = 2,
   parameter int BR_STALL  = 1,
   parameter int FLUSH_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        inst_valid,
   input  logic [1:0]  inst_class,
   output logic        inst_ready,
   input  logic        busy_alu0,
   input  logic        busy_alu1,
   input  logic        busy_ls,
   input  logic        busy_branch,
   input  logic        br_done,
   input  logic        br_taken,
   output logic        en_alu0,
   output logic        en_alu1,
   output logic        en_ls,
   output logic        en_branch,
   output logic        flush,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   localparam logic [1:0] CLS_ALU    = 2'd0;
   localparam logic [1:0] CLS_LS     = 2'd1;
   localparam logic [1:0] CLS_BRANCH = 2'd2;
   localparam logic [1:0] CLS_NOP    = 2'd3;

   localparam int RW = (BUSY_LAT < 1) ? 1 : $clog2(BUSY_LAT + 1);
   localparam int FW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

   // Index order everywhere: 0=alu0, 1=alu1, 2=ls, 3=branch
   state_t          state;
   logic            rr_ptr;
   logic [FW-1:0]   flush_cnt;
   logic [3:0]      resv;
   logic [RW-1:0]   resv_cnt [4];
   logic [3:0]      busy_vec;
   logic [3:0]      free_vec;
   logic [3:0]      target;
   logic [3:0]      en_vec;
   logic            class_allowed;
   logic            target_ok;

   assign busy_vec = {busy_branch, busy_ls, busy_alu1, busy_alu0};
   assign free_vec = ~busy_vec & ~resv;
   assign flush    = (state == FLUSH);

   // Target selection and the combinational accept / allocate handshake
   always_comb begin
      target        = 4'b0000;
      target_ok     = 1'b0;
      class_allowed = 1'b0;
      case (state)
         ISSUE:   class_allowed = 1'b1;
         BR_WAIT: class_allowed = (BR_STALL == 0) && (inst_class != CLS_BRANCH);
         FLUSH:   class_allowed = 1'b0;
         default: class_allowed = 1'b0;
      endcase
      case (inst_class)
         CLS_ALU: begin
            if (rr_ptr == 1'b0) begin
               if (free_vec[0])      target = 4'b0001;
               else if (free_vec[1]) target = 4'b0010;
               else                  target = 4'b0000;
            end else begin
               if (free_vec[1])      target = 4'b0010;
               else if (free_vec[0]) target = 4'b0001;
               else                  target = 4'b0000;
            end
            target_ok = |target;
         end
         CLS_LS: begin
            target    = free_vec[2] ? 4'b0100 : 4'b0000;
            target_ok = free_vec[2];
         end
         CLS_BRANCH: begin
            target    = free_vec[3] ? 4'b1000 : 4'b0000;
            target_ok = free_vec[3];
         end
         CLS_NOP: begin
            target    = 4'b0000;
            target_ok = 1'b1;
         end
         default: begin
            target    = 4'b0000;
            target_ok = 1'b0;
         end
      endcase
      inst_ready = rdy & inst_valid & class_allowed & target_ok;
      if (inst_ready) begin
         en_vec = target;
      end else begin
         en_vec = 4'b0000;
      end
   end

   assign en_alu0   = en_vec[0];
   assign en_alu1   = en_vec[1];
   assign en_ls     = en_vec[2];
   assign en_branch = en_vec[3];

   // Per-RS reservations: held until the RS reports busy or BUSY_LAT cycles elapse
   always_ff @(posedge clk) begin
      if (rst) begin
         resv <= 4'b0000;
         for (int i = 0; i < 4; i++) resv_cnt[i] <= '0;
      end else if (rdy) begin
         if (state == FLUSH) begin
            resv <= 4'b0000;
            for (int i = 0; i < 4; i++) resv_cnt[i] <= '0;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (en_vec[i]) begin
                  resv[i]     <= 1'b1;
                  resv_cnt[i] <= RW'(BUSY_LAT);
               end else if (resv[i]) begin
                  if (busy_vec[i] || (resv_cnt[i] <= RW'(1))) begin
                     resv[i]     <= 1'b0;
                     resv_cnt[i] <= '0;
                  end else begin
                     resv_cnt[i] <= resv_cnt[i] - RW'(1);
                  end
               end
            end
         end
      end
   end

   // Issue FSM, ALU round-robin pointer and saturating stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ISSUE;
         rr_ptr    <= 1'b0;
         flush_cnt <= '0;
         stall_cnt <= 16'h0000;
      end else if (rdy) begin
         if (inst_valid && !inst_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
         end
         // Pointer moves to whichever ALU was not just used
         if (en_vec[0]) begin
            rr_ptr <= 1'b1;
         end else if (en_vec[1]) begin
            rr_ptr <= 1'b0;
         end
         case (state)
            ISSUE: begin
               if (en_vec[3]) state <= BR_WAIT;
            end
            BR_WAIT: begin
               if (br_done) begin
                  if (br_taken) begin
                     state     <= FLUSH;
                     flush_cnt <= FW'(FLUSH_CYC - 1);
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= ISSUE;
               end else begin
                  flush_cnt <= flush_cnt - FW'(1);
               end
            end
            default: state <= ISSUE;
         endcase
      end
   end

endmodule
